// File: rtl/xgmii_lpbk_pkg.sv
// Shared XGMII constants, frame-state encoding and control-character helpers
// for the loopback/bypass multiplexer.
package xgmii_lpbk_pkg;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707_0707_0707_0707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
  localparam logic [7:0]  XGMII_START  = 8'hFB;
  localparam logic [7:0]  XGMII_TERM   = 8'hFD;
  localparam logic [7:0]  XGMII_ERR    = 8'hFE;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } frm_st_e;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
  } xgmii_word_t;

  // Start is only recognised in lane 0.
  function automatic logic is_start(input logic [63:0] d, input logic [7:0] c);
    return c[0] && (d[7:0] == XGMII_START);
  endfunction

  // Terminate may sit in any lane.
  function automatic logic has_term(input logic [63:0] d, input logic [7:0] c);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] && (d[8*i +: 8] == XGMII_TERM)) t = 1'b1;
    end
    return t;
  endfunction

endpackage

// File: rtl/xgmii_frm_trk.sv
// Frame-state tracker for one port on one stream.
//   state    | meaning
//   IDLE     | between frames; a mode change is allowed for this port
//   IN_FRAME | start seen, waiting for terminate
module xgmii_frm_trk
  import xgmii_lpbk_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        vld_i,
  input  logic [63:0] d_i,
  input  logic [7:0]  c_i,
  output logic        idle_o,
  output logic        start_o
);

  frm_st_e st_q;
  logic    start_w;
  logic    term_w;

  assign start_w = is_start(d_i, c_i);
  assign term_w  = has_term(d_i, c_i);
  assign idle_o  = (st_q == IDLE);
  assign start_o = vld_i && start_w;

  // Follow frame boundaries of words tagged with this port; start+term in one word stays IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q <= IDLE;
    end else if (vld_i) begin
      case (st_q)
        IDLE:     if (start_w && !term_w) st_q <= IN_FRAME;
        IN_FRAME: if (term_w) st_q <= IDLE;
        default:  st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/xgmii_lpbk_mux.sv
// Time-multiplexed XGMII loopback/bypass mux. Per port, rx carries either the
// looped tx stream or the external stream; modes switch only between frames.
// Optional build macro XGMII_LPBK_ERR_INJ_EN adds per-port error injection.
module xgmii_lpbk_mux
  import xgmii_lpbk_pkg::*;
#(
  parameter int PORTS  = 4,
  parameter int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int DELAY  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                   I_156m25_clk,
  input  logic                   I_rst_n,
  input  logic [63:0]            I_xgmii_txd,
  input  logic [7:0]             I_xgmii_txc,
  input  logic [PORT_W-1:0]      I_xgmii_txport_num,
  input  logic [63:0]            I_ext_rxd,
  input  logic [7:0]             I_ext_rxc,
  input  logic [PORT_W-1:0]      I_ext_rxport_num,
  input  logic [PORTS-1:0]       I_lpbk_req,
`ifdef XGMII_LPBK_ERR_INJ_EN
  input  logic [PORTS-1:0]       I_err_inj,
`endif
  input  logic                   I_cnt_clr,
  output logic [63:0]            O_xgmii_rxd,
  output logic [7:0]             O_xgmii_rxc,
  output logic [PORT_W-1:0]      O_xgmii_rxport_num,
  output logic [PORTS-1:0]       O_lpbk_active,
  output logic [PORTS*CNT_W-1:0] O_lpbk_frm_cnt
);

  localparam int TAGS = 2 ** PORT_W;

  logic [PORTS-1:0] tx_hit;
  logic [PORTS-1:0] tx_idle;
  logic [PORTS-1:0] tx_start;
  logic [PORTS-1:0] ex_idle;
  logic [PORTS-1:0] ex_start;

  logic [PORTS-1:0] active_q;
  logic [PORTS-1:0] active_d;
  logic [PORTS-1:0] mode_upd;

  // Tags beyond PORTS index zero-padding and therefore always select external.
  logic [TAGS-1:0]  active_tag;
  logic             sel_tx;
  logic             tx_term_w;
  logic [PORTS-1:0] cnt_inc;

  xgmii_word_t       s0_w;
  logic [PORT_W-1:0] s0_port;
  xgmii_word_t       pipe_q [DELAY];
  logic [PORT_W-1:0] port_q [DELAY];
  logic [CNT_W-1:0]  cnt_q  [PORTS];

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic ex_hit;
    assign tx_hit[p] = (I_xgmii_txport_num == PORT_W'(p));
    assign ex_hit    = (I_ext_rxport_num == PORT_W'(p));

    xgmii_frm_trk u_tx_trk (
      .clk_i   (I_156m25_clk),
      .rst_n_i (I_rst_n),
      .vld_i   (tx_hit[p]),
      .d_i     (I_xgmii_txd),
      .c_i     (I_xgmii_txc),
      .idle_o  (tx_idle[p]),
      .start_o (tx_start[p])
    );

    xgmii_frm_trk u_ex_trk (
      .clk_i   (I_156m25_clk),
      .rst_n_i (I_rst_n),
      .vld_i   (ex_hit),
      .d_i     (I_ext_rxd),
      .c_i     (I_ext_rxc),
      .idle_o  (ex_idle[p]),
      .start_o (ex_start[p])
    );

    assign O_lpbk_frm_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
  end

  // A request is only accepted while both streams are between frames and no frame is starting.
  assign mode_upd   = tx_idle & ex_idle & ~tx_start & ~ex_start;
  assign active_d   = (mode_upd & I_lpbk_req) | (~mode_upd & active_q);
  assign active_tag = TAGS'(active_q);
  assign sel_tx     = active_tag[I_xgmii_txport_num];
  assign tx_term_w  = has_term(I_xgmii_txd, I_xgmii_txc);
  assign cnt_inc    = tx_hit & {PORTS{sel_tx && tx_term_w}};

`ifdef XGMII_LPBK_ERR_INJ_EN
  logic [PORTS-1:0] inj_arm_q;
  logic [PORTS-1:0] inj_pend_q;
  logic             inj_fire;

  assign inj_fire = sel_tx && |(tx_hit & inj_pend_q);

  // Arm on request, go pending at the next looped start, fire on that port's following tx word.
  always_ff @(posedge I_156m25_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      inj_arm_q  <= '0;
      inj_pend_q <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (sel_tx && tx_hit[p]) begin
          if (inj_pend_q[p]) begin
            inj_pend_q[p] <= 1'b0;
          end else if (inj_arm_q[p] && tx_start[p]) begin
            inj_pend_q[p] <= 1'b1;
            inj_arm_q[p]  <= 1'b0;
          end
        end
        if (I_err_inj[p]) inj_arm_q[p] <= 1'b1;
      end
    end
  end
`endif

  // Stage 0: pick the source word with the mode registered before this cycle.
  always_comb begin
    s0_w.d  = sel_tx ? I_xgmii_txd : I_ext_rxd;
    s0_w.c  = sel_tx ? I_xgmii_txc : I_ext_rxc;
    s0_port = sel_tx ? I_xgmii_txport_num : I_ext_rxport_num;
`ifdef XGMII_LPBK_ERR_INJ_EN
    if (inj_fire) begin
      s0_w.d[15:8] = XGMII_ERR;
      s0_w.c[1]    = 1'b1;
    end
`endif
  end

  // Per-port mode register.
  always_ff @(posedge I_156m25_clk or negedge I_rst_n) begin
    if (!I_rst_n) active_q <= '0;
    else          active_q <= active_d;
  end

  // Fixed-latency shift pipeline; reset flushes every stage to idle.
  always_ff @(posedge I_156m25_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_q[i] <= {XGMII_IDLE_D, XGMII_IDLE_C};
        port_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= s0_w;
      port_q[0] <= s0_port;
      for (int i = 1; i < DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
        port_q[i] <= port_q[i-1];
      end
    end
  end

  // Saturating looped-frame counters; clear wins over increment.
  always_ff @(posedge I_156m25_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int p = 0; p < PORTS; p++) cnt_q[p] <= '0;
    end else if (I_cnt_clr) begin
      for (int p = 0; p < PORTS; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (cnt_inc[p] && (cnt_q[p] != '1)) cnt_q[p] <= cnt_q[p] + CNT_W'(1);
      end
    end
  end

  assign O_xgmii_rxd        = pipe_q[DELAY-1].d;
  assign O_xgmii_rxc        = pipe_q[DELAY-1].c;
  assign O_xgmii_rxport_num = port_q[DELAY-1];
  assign O_lpbk_active      = active_q;

endmodule

// File: tb/tb_xgmii_lpbk_mux.sv
// Scoreboard bench for xgmii_lpbk_mux: the driver pushes the expected rx word
// for every cycle it drives; a monitor pops and compares DELAY cycles later.
module tb_xgmii_lpbk_mux;

  localparam int PORTS  = 4;
  localparam int PORT_W = 2;
  localparam int DELAY  = 2;
  localparam int CNT_W  = 4;

  localparam logic [71:0] IDLE72 = {8'hFF, 64'h0707_0707_0707_0707};
  localparam logic [7:0]  TXS    = 8'hA1;
  localparam logic [7:0]  EXS    = 8'hE2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [63:0]            txd, exd, rxd;
  logic [7:0]             txc, exc, rxc;
  logic [PORT_W-1:0]      txp, exp_n, rxp;
  logic [PORTS-1:0]       req, act;
  logic [PORTS-1:0]       err_inj;
  logic                   clr;
  logic [PORTS*CNT_W-1:0] cnt;

  typedef struct {
    logic [63:0]       d;
    logic [7:0]        c;
    logic [PORT_W-1:0] p;
    int                due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  xgmii_lpbk_mux #(.PORTS(PORTS), .PORT_W(PORT_W), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .I_156m25_clk       (clk),
    .I_rst_n            (rst_n),
    .I_xgmii_txd        (txd),
    .I_xgmii_txc        (txc),
    .I_xgmii_txport_num (txp),
    .I_ext_rxd          (exd),
    .I_ext_rxc          (exc),
    .I_ext_rxport_num   (exp_n),
    .I_lpbk_req         (req),
`ifdef XGMII_LPBK_ERR_INJ_EN
    .I_err_inj          (err_inj),
`endif
    .I_cnt_clr          (clr),
    .O_xgmii_rxd        (rxd),
    .O_xgmii_rxc        (rxc),
    .O_xgmii_rxport_num (rxp),
    .O_lpbk_active      (act),
    .O_lpbk_frm_cnt     (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end, got running expected finished");
    $fatal(1);
  end

  // Word builder: start, data words, terminate in lane 1 (lane 0 tags the source).
  function automatic logic [71:0] mkw(input logic [7:0] src, input int p, input int f,
                                      input int w, input int last);
    logic [63:0] d;
    logic [7:0]  c;
    if (w == 0) begin
      c = 8'h01;
      d = {src, 8'(p), 8'(f), 32'h5555_5555, 8'hFB};
    end else if (w == last) begin
      c = 8'hFE;
      d = {48'h0707_0707_0707, 8'hFD, src};
    end else begin
      c = 8'h00;
      d = {src, 8'(p), 8'(f), 8'(w), 32'hDEAD_BEEF};
    end
    return {c, d};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int p);
    return cnt[p*CNT_W +: CNT_W];
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Called at a negedge: apply one word per stream, queue the expected rx word, advance a cycle.
  task automatic drive(input logic [71:0] tw, input int tp, input logic [71:0] ew, input int ep,
                       input logic [71:0] xw, input int xp);
    txd   = tw[63:0];
    txc   = tw[71:64];
    txp   = PORT_W'(tp);
    exd   = ew[63:0];
    exc   = ew[71:64];
    exp_n = PORT_W'(ep);
    sbq.push_back('{d: xw[63:0], c: xw[71:64], p: PORT_W'(xp), due: cyc + DELAY});
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    drive(IDLE72, 0, IDLE72, 0, IDLE72, 0);
  endtask

  // Monitor: compare the rx bus against the queue head once its due cycle arrives.
  always @(posedge clk) begin
    cyc++;
    #1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if (mon_e.due != cyc || rxd !== mon_e.d || rxc !== mon_e.c || rxp !== mon_e.p) begin
        errors++;
        $display("FAIL rx_word cyc=%0d: got d=%h c=%h port=%0d, expected d=%h c=%h port=%0d due=%0d",
                 cyc, rxd, rxc, rxp, mon_e.d, mon_e.c, mon_e.p, mon_e.due);
      end
    end
  end

  initial begin
    logic [71:0] w;
    rst_n   = 1'b0;
    req     = '0;
    clr     = 1'b0;
    err_inj = '0;
    txd = IDLE72[63:0]; txc = IDLE72[71:64]; txp = '0;
    exd = IDLE72[63:0]; exc = IDLE72[71:64]; exp_n = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state holds for DELAY+2 cycles.
    for (int i = 0; i < DELAY + 2; i++) begin
      @(negedge clk);
      chk("reset_state", 128'({rxd, rxc, rxp, act, cnt}),
          128'({64'h0707_0707_0707_0707, 8'hFF, 2'd0, 4'd0, 16'd0}));
    end

    // Basic loopback on port 0.
    req = 4'b0001;
    idle_cycle();
    idle_cycle();
    chk("basic_active", 128'(act), 128'(4'b0001));
    for (int wi = 0; wi < 10; wi++) begin
      w = mkw(TXS, 0, 0, wi, 9);
      drive(w, 0, IDLE72, 1, w, 0);
    end
    idle_cycle();
    chk("basic_cnt0", 128'(cnt_of(0)), 128'(4'd1));

    // Deferred switch: port-1 external frame in flight when loopback is requested.
    for (int wi = 0; wi < 6; wi++) begin
      if (wi == 3) req = 4'b0011;
      w = mkw(EXS, 1, 0, wi, 5);
      drive(IDLE72, 1, w, 1, w, 1);
      if (wi == 4) chk("defer_hold_mid", 128'(act), 128'(4'b0001));
    end
    chk("defer_hold_term", 128'(act), 128'(4'b0001));
    idle_cycle();
    chk("defer_apply", 128'(act), 128'(4'b0011));
    for (int wi = 0; wi < 4; wi++) begin
      w = mkw(TXS, 1, 1, wi, 3);
      drive(w, 1, IDLE72, 2, w, 1);
    end
    chk("defer_cnt1", 128'(cnt_of(1)), 128'(4'd1));

    // Interleaved ports: 0 and 2 looped, 1 and 3 external.
    req = 4'b0101;
    idle_cycle();
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    chk("intl_setup", 128'({act, cnt}), 128'({4'b0101, 16'h0000}));
    for (int r = 0; r < 15; r++) begin
      for (int p = 0; p < PORTS; p++) begin
        drive(mkw(TXS, p, r / 3, r % 3, 2), p, mkw(EXS, p, r / 3, r % 3, 2), p,
              (p % 2 == 0) ? mkw(TXS, p, r / 3, r % 3, 2) : mkw(EXS, p, r / 3, r % 3, 2), p);
      end
    end
    chk("intl_cnt", 128'(cnt), 128'({4'd0, 4'd5, 4'd0, 4'd5}));
    chk("intl_active", 128'(act), 128'(4'b0101));

    // Saturation and clear-priority on port 0.
    clr = 1'b1;
    idle_cycle();
    clr = 1'b0;
    for (int k = 0; k < 17; k++) begin
      drive(mkw(TXS, 0, k, 0, 1), 0, IDLE72, 1, mkw(TXS, 0, k, 0, 1), 0);
      drive(mkw(TXS, 0, k, 1, 1), 0, IDLE72, 1, mkw(TXS, 0, k, 1, 1), 0);
      if (k == 14) chk("sat_15", 128'(cnt_of(0)), 128'(4'd15));
    end
    chk("sat_17", 128'(cnt_of(0)), 128'(4'd15));
    drive(mkw(TXS, 0, 20, 0, 1), 0, IDLE72, 1, mkw(TXS, 0, 20, 0, 1), 0);
    clr = 1'b1;
    drive(mkw(TXS, 0, 20, 1, 1), 0, IDLE72, 1, mkw(TXS, 0, 20, 1, 1), 0);
    clr = 1'b0;
    chk("clr_prio", 128'(cnt_of(0)), 128'(4'd0));
    drive(mkw(TXS, 0, 21, 0, 1), 0, IDLE72, 1, mkw(TXS, 0, 21, 0, 1), 0);
    drive(mkw(TXS, 0, 21, 1, 1), 0, IDLE72, 1, mkw(TXS, 0, 21, 1, 1), 0);
    chk("cnt_after_clr", 128'(cnt_of(0)), 128'(4'd1));

`ifdef XGMII_LPBK_ERR_INJ_EN
    // Error injection: second word of the next looped port-0 frame is corrupted once.
    err_inj = 4'b0001;
    idle_cycle();
    err_inj = '0;
    for (int wi = 0; wi < 4; wi++) begin
      w = mkw(TXS, 0, 30, wi, 3);
      if (wi == 1) drive(w, 0, IDLE72, 1, {w[71:66], 1'b1, w[64:16], 8'hFE, w[7:0]}, 0);
      else         drive(w, 0, IDLE72, 1, w, 0);
    end
    for (int wi = 0; wi < 4; wi++) begin
      w = mkw(TXS, 0, 31, wi, 3);
      drive(w, 0, IDLE72, 1, w, 0);
    end
`endif

    // Asynchronous reset in the middle of a looped frame.
    drive(mkw(TXS, 0, 40, 0, 5), 0, IDLE72, 1, mkw(TXS, 0, 40, 0, 5), 0);
    drive(mkw(TXS, 0, 40, 1, 5), 0, IDLE72, 1, mkw(TXS, 0, 40, 1, 5), 0);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    txd = IDLE72[63:0]; txc = IDLE72[71:64]; txp = '0;
    exd = IDLE72[63:0]; exc = IDLE72[71:64]; exp_n = '0;
    #1;
    chk("async_rst", 128'({rxd, rxc, rxp, act, cnt}),
        128'({64'h0707_0707_0707_0707, 8'hFF, 2'd0, 4'd0, 16'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DELAY + 1; i++) idle_cycle();

    repeat (DELAY + 2) @(negedge clk);
    chk("sb_drain", 128'(sbq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
